// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a persistent carry flag (C) for
// multi-word ADC/SBB chains and a multi-cycle shift-add unsigned multiply.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand/opcode handshake (in_ready is combinational)
//   a, b, opcode          operands and operation select, captured on accept
//   out_valid / out_ready result handshake (out_valid is registered)
//   y, y_hi               result; y_hi is the MUL high half, 0 otherwise
//   carry_out, zero, parity, negative, overflow, invalid_op   result flags
//   busy                  multiply in progress
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no result held, ready for a new operation
// S_MUL    | shift-add multiply iterating, inputs ignored
// S_RESULT | result held on the outputs until out_ready
module alu_seq #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [3:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic [BUS_WIDTH-1:0] y_hi,
  output logic                 carry_out,
  output logic                 zero,
  output logic                 parity,
  output logic                 negative,
  output logic                 overflow,
  output logic                 invalid_op,
  output logic                 busy
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_XOR  = 4'd11;
  localparam logic [3:0] OP_SBB  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_CLRC = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESULT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    y_q, y_d, y_hi_q, y_hi_d;
  logic            co_q, co_d, zero_q, zero_d, par_q, par_d;
  logic            neg_q, neg_d, ov_q, ov_d, inv_q, inv_d;
  logic            c_q, c_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            is_mul;

  // single-cycle ALU, evaluated on the raw inputs and used only on accept
  logic [W-1:0]    alu_y;
  logic            alu_co, alu_ov, alu_inv, alu_c_we, alu_c_new;
  logic            arith, sub;
  logic [W-1:0]    opb;
  logic            cin;
  logic [W:0]      sum;

  // one shift-add multiply step
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  prod_step;

  // result load mux shared by the ALU path and the multiply completion
  logic            ld;
  logic [W-1:0]    ld_y, ld_y_hi;
  logic            ld_co, ld_ov, ld_inv;

  // ---------------- output comb ----------------
  always_comb begin
    busy      = (state_q == S_MUL);
    out_valid = (state_q == S_RESULT);
    in_ready  = (state_q != S_MUL) && (!out_valid || out_ready);
  end

  assign accept = in_valid && in_ready;
  assign is_mul = (opcode == OP_MUL);

  assign y          = y_q;
  assign y_hi       = y_hi_q;
  assign carry_out  = co_q;
  assign zero       = zero_q;
  assign parity     = par_q;
  assign negative   = neg_q;
  assign overflow   = ov_q;
  assign invalid_op = inv_q;

  // ---------------- ALU ----------------
  always_comb begin
    alu_y     = '0;
    alu_co    = 1'b0;
    alu_ov    = 1'b0;
    alu_inv   = 1'b0;
    alu_c_we  = 1'b0;
    alu_c_new = 1'b0;
    arith     = 1'b0;
    sub       = 1'b0;
    opb       = b;
    cin       = 1'b0;
    case (opcode)
      OP_ADD:  arith = 1'b1;
      OP_ADC:  begin arith = 1'b1; cin = c_q; end
      OP_SUB:  begin arith = 1'b1; sub = 1'b1; end
      OP_SBB:  begin arith = 1'b1; sub = 1'b1; cin = c_q; end
      OP_INC:  begin arith = 1'b1; opb = W'(1); end
      OP_DEC:  begin arith = 1'b1; sub = 1'b1; opb = W'(1); end
      OP_AND:  alu_y = a & b;
      OP_NOT:  alu_y = ~a;
      OP_ROL:  alu_y = {a[W-2:0], a[W-1]};
      OP_ROR:  alu_y = {a[0], a[W-1:1]};
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_CLRC: begin alu_c_we = 1'b1; alu_c_new = 1'b0; end
      OP_MUL:  alu_y = '0;
      default: alu_inv = 1'b1;
    endcase

    // bit W of a (W+1)-bit difference is set exactly when the result went negative (borrow)
    if (sub) sum = {1'b0, a} - {1'b0, opb} - {{W{1'b0}}, cin};
    else     sum = {1'b0, a} + {1'b0, opb} + {{W{1'b0}}, cin};

    if (arith) begin
      alu_y     = sum[W-1:0];
      alu_co    = sum[W];
      alu_c_we  = 1'b1;
      alu_c_new = sum[W];
      if (sub) alu_ov = (a[W-1] != opb[W-1]) && (sum[W-1] != a[W-1]);
      else     alu_ov = (a[W-1] == opb[W-1]) && (sum[W-1] != a[W-1]);
    end
  end

  // prod_q holds {partial_hi, remaining multiplier bits}; each step adds the
  // multiplicand into the high half on the current LSB and shifts right.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    prod_step = {mul_sum, prod_q[W-1:1]};
  end

  // ---------------- next-state comb ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = is_mul ? S_MUL : S_RESULT;
      end
      S_MUL: begin
        if (cnt_q == '0) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (accept)         state_d = is_mul ? S_MUL : S_RESULT;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath next ----------------
  always_comb begin
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    co_d    = co_q;
    zero_d  = zero_q;
    par_d   = par_q;
    neg_d   = neg_q;
    ov_d    = ov_q;
    inv_d   = inv_q;
    c_d     = c_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ld_y    = alu_y;
    ld_y_hi = '0;
    ld_co   = alu_co;
    ld_ov   = alu_ov;
    ld_inv  = alu_inv;

    if (accept) begin
      if (is_mul) begin
        mcand_d = a;
        prod_d  = {{W{1'b0}}, b};
        cnt_d   = CW'(W - 1);
      end else begin
        ld = 1'b1;
        if (alu_c_we) c_d = alu_c_new;
      end
    end

    if (state_q == S_MUL) begin
      prod_d = prod_step;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        ld      = 1'b1;
        ld_y    = prod_step[W-1:0];
        ld_y_hi = prod_step[2*W-1:W];
        ld_co   = |prod_step[2*W-1:W];
        ld_ov   = 1'b0;
        ld_inv  = 1'b0;
      end
    end

    if (ld) begin
      y_d    = ld_y;
      y_hi_d = ld_y_hi;
      co_d   = ld_co;
      ov_d   = ld_ov;
      inv_d  = ld_inv;
      zero_d = ~|{ld_y_hi, ld_y};
      par_d  = ^ld_y;
      neg_d  = ld_y[W-1];
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      y_hi_q  <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
      par_q   <= 1'b0;
      neg_q   <= 1'b0;
      ov_q    <= 1'b0;
      inv_q   <= 1'b0;
      c_q     <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      neg_q   <= neg_d;
      ov_q    <= ov_d;
      inv_q   <= inv_d;
      c_q     <= c_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (BUS_WIDTH=8).
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] opcode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y, y_hi;
  logic       carry_out, zero, parity, negative, overflow, invalid_op, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.BUS_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .y_hi       (y_hi),
    .carry_out  (carry_out),
    .zero       (zero),
    .parity     (parity),
    .negative   (negative),
    .overflow   (overflow),
    .invalid_op (invalid_op),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready=1, wait for its result, check latency and outputs.
  // zero/parity/negative follow directly from the hand-written result values.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ey, input logic [7:0] eyhi,
                        input logic eco, input logic eov, input logic einv, input int elat);
    int lat;
    int bsy;
    int rdy;
    logic [5:0] eflags;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; opcode = 4'd0;
    lat = 1; bsy = 0; rdy = 0;
    while (!out_valid && lat < 30) begin
      bsy += int'(busy);
      rdy += int'(in_ready);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    if (elat > 1) begin
      check({tag, "_busy_cycles"}, bsy, 8);
      check({tag, "_ready_in_mul"}, rdy, 0);
    end
    eflags = {eco, ({eyhi, ey} == 16'h0), ^ey, ey[7], eov, einv};
    check({tag, "_y"}, y, ey);
    check({tag, "_yhi"}, y_hi, eyhi);
    check({tag, "_flags"}, {carry_out, zero, parity, negative, overflow, invalid_op}, eflags);
  endtask

  initial begin
    int seen;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {out_valid, busy, in_ready, y_hi, y, carry_out, zero, parity, negative, overflow, invalid_op},
          {1'b0, 1'b0, 1'b1, 16'h0000, 6'b000000});
    @(negedge clk) rst_n = 1'b1;

    // carry chains
    run_op("add_ff_01", 4'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 0, 1);
    run_op("adc_10_20", 4'd2,  8'h10, 8'h20, 8'h31, 8'h00, 0, 0, 0, 1);
    run_op("sub_05_07", 4'd3,  8'h05, 8'h07, 8'hFE, 8'h00, 1, 0, 0, 1);
    run_op("sbb_10_01", 4'd12, 8'h10, 8'h01, 8'h0E, 8'h00, 0, 0, 0, 1);
    run_op("add_7f_01", 4'd1,  8'h7F, 8'h01, 8'h80, 8'h00, 0, 1, 0, 1);
    // invalid keeps C=1, seen by the following ADC
    run_op("add_set_c", 4'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 0, 1);
    run_op("op15",      4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 0, 0, 1, 1);
    run_op("adc_c_kept",4'd2,  8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 0, 1);
    // remaining single-cycle ops
    run_op("inc_7f",    4'd4,  8'h7F, 8'h00, 8'h80, 8'h00, 0, 1, 0, 1);
    run_op("dec_00",    4'd5,  8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 1);
    run_op("and",       4'd6,  8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 1);
    run_op("not",       4'd7,  8'h5A, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 1);
    run_op("rol",       4'd8,  8'h81, 8'h00, 8'h03, 8'h00, 0, 0, 0, 1);
    run_op("ror",       4'd9,  8'h81, 8'h00, 8'hC0, 8'h00, 0, 0, 0, 1);
    run_op("or",        4'd10, 8'h50, 8'h0A, 8'h5A, 8'h00, 0, 0, 0, 1);
    run_op("xor",       4'd11, 8'hFF, 8'h0F, 8'hF0, 8'h00, 0, 0, 0, 1);
    // C=1 from DEC survives logic ops; CLRC clears it
    run_op("clrc",      4'd14, 8'h55, 8'h66, 8'h00, 8'h00, 0, 0, 0, 1);
    run_op("adc_after_clrc", 4'd2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
    run_op("op0",       4'd0,  8'h12, 8'h34, 8'h00, 8'h00, 0, 0, 1, 1);

    // multiply; C set beforehand must survive it
    run_op("add_set_c2",4'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 0, 1);
    run_op("mul_ff_ff", 4'd13, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1, 0, 0, 9);
    run_op("mul_0d_0b", 4'd13, 8'h0D, 8'h0B, 8'h8F, 8'h00, 0, 0, 0, 9);
    run_op("mul_10_20", 4'd13, 8'h10, 8'h20, 8'h00, 8'h02, 1, 0, 0, 9);
    run_op("adc_after_mul", 4'd2, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 0, 1);

    // backpressure: ADD result held for 3 cycles while an XOR waits
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd1; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    out_ready = 1'b0;
    opcode = 4'd11; a = 8'h0F; b = 8'hFF;
    check("bp_first", {out_valid, y}, {1'b1, 8'h46});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, y, y_hi, carry_out, zero}, {1'b1, 1'b0, 8'h46, 8'h00, 1'b0, 1'b0});
    end
    @(negedge clk) out_ready = 1'b1;
    #1 check("bp_ready_release", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_queued", {out_valid, y}, {1'b1, 8'hF0});

    // reset during multiply iteration 4
    run_op("add_set_c3",4'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 0, 1);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd13; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mul_state", {busy, out_valid, in_ready}, {1'b0, 1'b0, 1'b1});
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    check("rst_no_result", seen, 0);
    run_op("adc_after_rst", 4'd2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
